sc_image_sequencer: RTL and testbench

Command generator driving the 2-bit command bus of the image frame counter: it issues the clear, increment and hold commands that step the Frogger sprite/image animation through frames 0..LAST_FRAME at a fixed frame period. It reads the counter's 3-bit value back to decide wrap or finish, and offers start/stop/pause control to the game FSM. It sits between the game control logic and the image counter, in the same clock domain.

---
 rtl/sc_image_sequencer_if.sv | 36 +++
 rtl/sc_image_sequencer.sv | 103 ++++++++++
 tb/tb_sc_image_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_image_sequencer_if.sv
// Control and command bus between the game FSM, the image frame counter and sc_image_sequencer.
// master = game/counter side (drives start/stop/pause and count feedback), slave = sequencer.
interface sc_image_sequencer_if #(
  parameter int DATAWIDTH_3 = 3
);
  logic                   SC_IMAGE_SEQUENCER_start_InLow;
  logic                   SC_IMAGE_SEQUENCER_stop_InLow;
  logic                   SC_IMAGE_SEQUENCER_pause_InLow;
  logic [DATAWIDTH_3-1:0] SC_IMAGE_SEQUENCER_count_InBus;
  logic [DATAWIDTH_3-2:0] SC_IMAGE_SEQUENCER_CUENTA_OutBus;
  logic                   SC_IMAGE_SEQUENCER_busy_Out;
  logic                   SC_IMAGE_SEQUENCER_done_Out;
  logic                   SC_IMAGE_SEQUENCER_frametick_Out;

  modport master (
    output SC_IMAGE_SEQUENCER_start_InLow,
    output SC_IMAGE_SEQUENCER_stop_InLow,
    output SC_IMAGE_SEQUENCER_pause_InLow,
    output SC_IMAGE_SEQUENCER_count_InBus,
    input  SC_IMAGE_SEQUENCER_CUENTA_OutBus,
    input  SC_IMAGE_SEQUENCER_busy_Out,
    input  SC_IMAGE_SEQUENCER_done_Out,
    input  SC_IMAGE_SEQUENCER_frametick_Out
  );

  modport slave (
    input  SC_IMAGE_SEQUENCER_start_InLow,
    input  SC_IMAGE_SEQUENCER_stop_InLow,
    input  SC_IMAGE_SEQUENCER_pause_InLow,
    input  SC_IMAGE_SEQUENCER_count_InBus,
    output SC_IMAGE_SEQUENCER_CUENTA_OutBus,
    output SC_IMAGE_SEQUENCER_busy_Out,
    output SC_IMAGE_SEQUENCER_done_Out,
    output SC_IMAGE_SEQUENCER_frametick_Out
  );
endinterface

// File: rtl/sc_image_sequencer.sv
// Frame-period command generator for the image counter: clear/increment/hold pulses, one-edge registered outputs.
// No backpressure; pause freezes the prescaler, stop > start > pause > prescaler tick each edge.
module sc_image_sequencer #(
  parameter int DATAWIDTH_3     = 3,
  parameter int PRESCALER_WIDTH = 26,
  parameter int FRAME_PERIOD    = 25000000,
  parameter int LAST_FRAME      = 5,
  parameter bit LOOP            = 1'b1
) (
  input logic                 SC_IMAGE_COUNTER_CLOCK_50,
  input logic                 SC_IMAGE_COUNTER_RESET_InHigh,
  sc_image_sequencer_if.slave seq_if
);
  localparam int CW = DATAWIDTH_3 - 1;

  localparam logic [1:0] STATE_IDLE = 2'b00;
  localparam logic [1:0] STATE_RUN  = 2'b01;
  localparam logic [1:0] STATE_DONE = 2'b10;

  localparam logic [CW-1:0] CMD_INC  = CW'(0);
  localparam logic [CW-1:0] CMD_HOLD = CW'(1);
  localparam logic [CW-1:0] CMD_CLR  = CW'(2);

  localparam logic [PRESCALER_WIDTH-1:0] PRESC_LAST = PRESCALER_WIDTH'(FRAME_PERIOD - 1);
  localparam logic [PRESCALER_WIDTH-1:0] PRESC_ONE  = PRESCALER_WIDTH'(1);
  localparam logic [DATAWIDTH_3-1:0]     LAST_CNT   = DATAWIDTH_3'(LAST_FRAME);

  logic [1:0]                 state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
  logic [CW-1:0]              cuenta_q, cuenta_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       tick_q, tick_d;

  logic start_i, stop_i, pause_i;
  logic [DATAWIDTH_3-1:0] count_i;

  assign start_i = ~seq_if.SC_IMAGE_SEQUENCER_start_InLow;
  assign stop_i  = ~seq_if.SC_IMAGE_SEQUENCER_stop_InLow;
  assign pause_i = ~seq_if.SC_IMAGE_SEQUENCER_pause_InLow;
  assign count_i = seq_if.SC_IMAGE_SEQUENCER_count_InBus;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cuenta_d = CMD_HOLD;
    busy_d   = busy_q;
    done_d   = done_q;
    tick_d   = 1'b0;
    if (stop_i) begin
      state_d = STATE_IDLE;
      presc_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (start_i) begin
      state_d  = STATE_RUN;
      presc_d  = '0;
      cuenta_d = CMD_CLR;
      busy_d   = 1'b1;
      done_d   = 1'b0;
    end else if (state_q == STATE_RUN && !pause_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
        // Out-of-range feedback also takes the increment path; the counter wraps itself.
        if (count_i != LAST_CNT) begin
          cuenta_d = CMD_INC;
        end else if (LOOP) begin
          cuenta_d = CMD_CLR;
        end else begin
          state_d = STATE_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end
  end

  always_ff @(posedge SC_IMAGE_COUNTER_CLOCK_50 or posedge SC_IMAGE_COUNTER_RESET_InHigh) begin
    if (SC_IMAGE_COUNTER_RESET_InHigh) begin
      state_q  <= STATE_IDLE;
      presc_q  <= '0;
      cuenta_q <= CMD_HOLD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cuenta_q <= cuenta_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tick_q   <= tick_d;
    end
  end

  assign seq_if.SC_IMAGE_SEQUENCER_CUENTA_OutBus = cuenta_q;
  assign seq_if.SC_IMAGE_SEQUENCER_busy_Out      = busy_q;
  assign seq_if.SC_IMAGE_SEQUENCER_done_Out      = done_q;
  assign seq_if.SC_IMAGE_SEQUENCER_frametick_Out = tick_q;
endmodule

// File: tb/tb_sc_image_sequencer.sv
// Bench for sc_image_sequencer: one-shot (LOOP=0) and looping (LOOP=1) instances share the control inputs,
// each closes the loop through a small 3-bit image counter.
module tb_sc_image_sequencer;
  localparam int FP = 4;
  localparam int LF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_n = 1'b1;
  logic stop_n = 1'b1;
  logic pause_n = 1'b1;
  logic [2:0] cnt0, cnt1;
  logic chk_en = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sc_image_sequencer_if #(.DATAWIDTH_3(3)) if0 ();
  sc_image_sequencer_if #(.DATAWIDTH_3(3)) if1 ();

  assign if0.SC_IMAGE_SEQUENCER_start_InLow = start_n;
  assign if0.SC_IMAGE_SEQUENCER_stop_InLow  = stop_n;
  assign if0.SC_IMAGE_SEQUENCER_pause_InLow = pause_n;
  assign if0.SC_IMAGE_SEQUENCER_count_InBus = cnt0;
  assign if1.SC_IMAGE_SEQUENCER_start_InLow = start_n;
  assign if1.SC_IMAGE_SEQUENCER_stop_InLow  = stop_n;
  assign if1.SC_IMAGE_SEQUENCER_pause_InLow = pause_n;
  assign if1.SC_IMAGE_SEQUENCER_count_InBus = cnt1;

  sc_image_sequencer #(.DATAWIDTH_3(3), .PRESCALER_WIDTH(26), .FRAME_PERIOD(FP),
                       .LAST_FRAME(LF), .LOOP(1'b0)) dut0 (
    .SC_IMAGE_COUNTER_CLOCK_50(clk),
    .SC_IMAGE_COUNTER_RESET_InHigh(rst),
    .seq_if(if0.slave)
  );

  sc_image_sequencer #(.DATAWIDTH_3(3), .PRESCALER_WIDTH(26), .FRAME_PERIOD(FP),
                       .LAST_FRAME(LF), .LOOP(1'b1)) dut1 (
    .SC_IMAGE_COUNTER_CLOCK_50(clk),
    .SC_IMAGE_COUNTER_RESET_InHigh(rst),
    .seq_if(if1.slave)
  );

  // Image counters: 00 increment, 10 clear, anything else hold.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      case (if0.SC_IMAGE_SEQUENCER_CUENTA_OutBus)
        2'b00: cnt0 <= cnt0 + 3'd1;
        2'b10: cnt0 <= '0;
        default: ;
      endcase
      case (if1.SC_IMAGE_SEQUENCER_CUENTA_OutBus)
        2'b00: cnt1 <= cnt1 + 3'd1;
        2'b10: cnt1 <= '0;
        default: ;
      endcase
    end
  end

  logic [4:0] obs [2];
  assign obs[0] = {if0.SC_IMAGE_SEQUENCER_CUENTA_OutBus, if0.SC_IMAGE_SEQUENCER_busy_Out,
                   if0.SC_IMAGE_SEQUENCER_done_Out, if0.SC_IMAGE_SEQUENCER_frametick_Out};
  assign obs[1] = {if1.SC_IMAGE_SEQUENCER_CUENTA_OutBus, if1.SC_IMAGE_SEQUENCER_busy_Out,
                   if1.SC_IMAGE_SEQUENCER_done_Out, if1.SC_IMAGE_SEQUENCER_frametick_Out};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts un-paused running cycles since the last start; every FP-th one is a
  // frame boundary, and the frame being left is (boundaries so far) mod (LF+1).
  bit         m_run [2];
  bit         m_fin [2];
  int         m_k [2];
  int         m_ticks [2];
  logic [4:0] m_exp [2];

  always @(posedge clk or posedge rst) begin
    logic [1:0] cmd;
    logic       tk;
    int         fr;
    for (int i = 0; i < 2; i++) begin
      cmd = 2'b01;
      tk  = 1'b0;
      if (rst) begin
        m_run[i] = 0; m_fin[i] = 0; m_k[i] = 0; m_ticks[i] = 0;
      end else if (!stop_n) begin
        m_run[i] = 0; m_fin[i] = 0;
      end else if (!start_n) begin
        m_run[i] = 1; m_fin[i] = 0; m_k[i] = 0; m_ticks[i] = 0;
        cmd = 2'b10;
      end else if (m_run[i] && pause_n) begin
        m_k[i]++;
        if (m_k[i] % FP == 0) begin
          tk = 1'b1;
          fr = m_ticks[i] % (LF + 1);
          m_ticks[i]++;
          if (fr != LF) cmd = 2'b00;
          else if (i == 1) cmd = 2'b10;
          else begin
            m_run[i] = 0; m_fin[i] = 1;
          end
        end
      end
      m_exp[i] = {cmd, m_run[i], m_fin[i], tk};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dut0", 32'(obs[0]), 32'(m_exp[0]));
      check("model_dut1", 32'(obs[1]), 32'(m_exp[1]));
    end
  end

  typedef struct {
    logic       st_n;
    logic       sp_n;
    logic       pa_n;
    logic [4:0] exp;   // {cuenta, busy, done, frametick}
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cyc, ticks;
    logic quiet;
    logic [2:0] frozen;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 5'b01_0_0_0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 5'b10_1_0_0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 5'b01_1_0_0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 5'b01_1_0_0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 5'b01_1_0_0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 5'b00_1_0_1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 5'b01_1_0_0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 5'b01_1_0_0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 5'b01_0_0_0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 5'b01_0_0_0};

    repeat (3) @(negedge clk);
    check("reset_dut0", 32'(obs[0]), 32'(5'b01_0_0_0));
    check("reset_dut1", 32'(obs[1]), 32'(5'b01_0_0_0));
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_n = tbl[i].st_n; stop_n = tbl[i].sp_n; pause_n = tbl[i].pa_n;
      @(negedge clk);
      check($sformatf("vec%0d_dut0", i), 32'(obs[0]), 32'(tbl[i].exp));
      check($sformatf("vec%0d_dut1", i), 32'(obs[1]), 32'(tbl[i].exp));
    end
    check("stop_frozen_cnt0", 32'(cnt0), 32'd1);
    repeat (6) @(negedge clk);
    check("stop_frozen_cnt0_later", 32'(cnt0), 32'd1);
    check("stop_frozen_cnt1_later", 32'(cnt1), 32'd1);

    // Full one-shot run: six frames, done at the sixth boundary.
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    cyc = 0; ticks = 0;
    while (!if0.SC_IMAGE_SEQUENCER_done_Out && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (if0.SC_IMAGE_SEQUENCER_frametick_Out) ticks++;
    end
    check("run_cycles_to_done", 32'(cyc), 32'd24);
    check("run_tick_count", 32'(ticks), 32'd6);
    check("run_final_cnt0", 32'(cnt0), 32'd5);
    check("loop_clear_cmd", 32'(if1.SC_IMAGE_SEQUENCER_CUENTA_OutBus), 32'(2'b10));
    check("loop_busy", 32'(if1.SC_IMAGE_SEQUENCER_busy_Out), 32'd1);
    @(negedge clk);
    check("loop_cnt1_wrapped", 32'(cnt1), 32'd0);
    repeat (8) @(negedge clk);
    check("done_steady", 32'(obs[0]), 32'(5'b01_0_1_0));
    check("done_cnt0_held", 32'(cnt0), 32'd5);

    // Restart from DONE.
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    check("restart_done", 32'(obs[0]), 32'(5'b10_1_0_0));
    @(negedge clk);
    check("restart_done_cnt0", 32'(cnt0), 32'd0);

    // Restart mid-run once the counter reaches 3; a full period must follow.
    cyc = 0;
    while (cnt0 != 3'd3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_cnt3", 32'(cnt0), 32'd3);
    start_n = 1'b0;
    @(negedge clk);
    start_n = 1'b1;
    check("restart_run_cmd", 32'(if0.SC_IMAGE_SEQUENCER_CUENTA_OutBus), 32'(2'b10));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("restart_run_cnt0", 32'(cnt0), 32'd0);
    end while (!if0.SC_IMAGE_SEQUENCER_frametick_Out && cyc < 20);
    check("restart_full_period", 32'(cyc), 32'd4);

    // Pause 3 cycles inside the next frame: frame stretches to 7, no command meanwhile.
    cyc = 0; quiet = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && cyc <= 4 && if0.SC_IMAGE_SEQUENCER_CUENTA_OutBus != 2'b01) quiet = 1'b0;
      if (cyc == 1) pause_n = 1'b0;
      if (cyc == 4) pause_n = 1'b1;
    end while (!if0.SC_IMAGE_SEQUENCER_frametick_Out && cyc < 20);
    pause_n = 1'b1;
    check("pause_frame_len", 32'(cyc), 32'd7);
    check("pause_no_cmd", 32'(quiet), 32'd1);

    // Start held low re-issues clear every cycle.
    start_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cont_restart_cmd", 32'(if0.SC_IMAGE_SEQUENCER_CUENTA_OutBus), 32'(2'b10));
    end
    start_n = 1'b1;

    // Asynchronous reset mid-frame.
    repeat (5) @(negedge clk);
    frozen = cnt0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dut0", 32'(obs[0]), 32'(5'b01_0_0_0));
    check("async_rst_dut1", 32'(obs[1]), 32'(5'b01_0_0_0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_idle", 32'(obs[0]), 32'(5'b01_0_0_0));
    check("post_rst_cnt0", 32'(cnt0), 32'd0);
    if (frozen > 3'd5) check("cnt_range", 32'(frozen), 32'd5);

    // Randomized control traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      stop_n  = ($urandom_range(0, 63) != 0);
      start_n = ($urandom_range(0, 47) != 0);
      pause_n = ($urandom_range(0, 5) != 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
